pixel_tx_framer: RTL and testbench

- Sits downstream of the pixel-iteration control loop and upstream of uart_tx.
- Buffers 8-bit iteration counts in a small FIFO and wraps each block's pixels into a frame: header byte, PAYLOAD_LEN payload bytes, then an XOR checksum byte.
- Paces bytes to uart_tx with the tx_start/tx_active handshake.
- Decouples pixel production from UART throughput so the core can start the next pixel while earlier counts are still serialising.

---
 rtl/mandelbrot_pkg.sv | 16 +
 rtl/pixel_tx_framer_if.sv | 22 ++
 rtl/pixel_tx_framer_byte_fifo.sv | 52 +++++
 rtl/pixel_tx_framer.sv | 115 +++++++++++
 tb/tb_pixel_tx_framer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared constants and encodings for the Mandelbrot block pipeline.
// The pixel TX framer takes its frame header, payload length and state encoding from here.
package mandelbrot_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int FRAME_PAYLOAD_LEN = BLOCK_SIZE * BLOCK_SIZE;
  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_SUM  = 2'd3
  } framer_state_t;

endpackage

// File: rtl/pixel_tx_framer_if.sv
// Byte-stream signals between the pixel core, the framer and uart_tx.
// Input side: a byte moves on any CLK edge where in_valid && in_ready. in_valid may
// rise at any time, and in_ready does not depend on in_valid.
// TX side: tx_start is a one-cycle launch. uart_tx raises tx_active one cycle later.
interface pixel_tx_framer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_active;

  modport slave (
    input  in_data, in_valid, tx_active,
    output in_ready, tx_data, tx_start
  );

  modport master (
    output in_data, in_valid, tx_active,
    input  in_ready, tx_data, tx_start
  );
endinterface

// File: rtl/pixel_tx_framer_byte_fifo.sv
// First-word-fall-through byte FIFO with a synchronous active-low reset.
// dout shows the head entry whenever empty is low.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule

// File: rtl/pixel_tx_framer.sv
// Buffers pixel iteration counts and frames them for uart_tx. Each frame is the header,
// PAYLOAD_LEN payload bytes and an XOR checksum of the payload.
module pixel_tx_framer
  import mandelbrot_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         PAYLOAD_LEN = FRAME_PAYLOAD_LEN,
  parameter logic [7:0] HEADER      = FRAME_HEADER
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               frame_start,
  pixel_tx_framer_if.slave   io,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_err,
  output framer_state_t      dbg_state
);
  localparam logic [16:0] LAST_IDX = 17'(PAYLOAD_LEN - 1);

  framer_state_t state, state_nxt;
  logic        tx_start_q, frame_done_q, frame_err_q;
  logic [7:0]  tx_data_q, checksum;
  logic [16:0] pay_cnt;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  fifo_dout;
  logic        launch_ok, launch, sum_launch, frame_open, last_pay;
  logic [7:0]  launch_byte;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (io.in_valid),
    .din   (io.in_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The guard on tx_start_q covers the cycle before uart_tx raises tx_active.
  assign launch_ok  = !io.tx_active && !tx_start_q;
  assign frame_open = (state == ST_IDLE) && frame_start;
  assign last_pay   = (pay_cnt == LAST_IDX);

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // The header may launch straight from IDLE so it can go out on the cycle after frame_start.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (frame_start) state_nxt = launch_ok ? ST_PAY : ST_HDR;
      ST_HDR:  if (launch_ok) state_nxt = ST_PAY;
      ST_PAY:  if (launch_ok && !fifo_empty && last_pay) state_nxt = ST_SUM;
      ST_SUM:  if (launch_ok) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    launch      = 1'b0;
    sum_launch  = 1'b0;
    fifo_pop    = 1'b0;
    launch_byte = HEADER;
    case (state)
      ST_IDLE: launch = frame_start && launch_ok;
      ST_HDR:  launch = launch_ok;
      ST_PAY: begin
        fifo_pop    = launch_ok && !fifo_empty;
        launch      = fifo_pop;
        launch_byte = fifo_dout;
      end
      ST_SUM: begin
        launch      = launch_ok;
        sum_launch  = launch_ok;
        launch_byte = checksum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      checksum     <= 8'h00;
      pay_cnt      <= 17'd0;
    end else begin
      tx_start_q   <= launch;
      frame_done_q <= sum_launch;
      if (launch) tx_data_q <= launch_byte;
      if (frame_start && state != ST_IDLE) frame_err_q <= 1'b1;
      if (frame_open) begin
        checksum <= 8'h00;
        pay_cnt  <= 17'd0;
      end else if (fifo_pop) begin
        checksum <= checksum ^ fifo_dout;
        pay_cnt  <= pay_cnt + 17'd1;
      end
    end
  end

  assign io.in_ready = !fifo_full;
  assign io.tx_data  = tx_data_q;
  assign io.tx_start = tx_start_q;
  assign busy        = (state != ST_IDLE);
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign dbg_state   = state;
endmodule

// File: tb/tb_pixel_tx_framer.sv
// Directed bench for pixel_tx_framer. It drives a 4-byte-payload instance and a 4096-byte
// instance, each attached to a behavioural uart_tx that records every launched byte.
module tb_pixel_tx_framer;
  import mandelbrot_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic fs_s = 1'b0, fs_l = 1'b0;
  logic busy_s, done_s, err_s, busy_l, done_l, err_l;
  framer_state_t state_s, state_l;

  pixel_tx_framer_if s_if ();
  pixel_tx_framer_if l_if ();

  pixel_tx_framer #(.DEPTH(16), .PAYLOAD_LEN(4), .HEADER(8'hA5)) dut_s (
    .CLK(CLK), .RST_N(RST_N), .frame_start(fs_s), .io(s_if),
    .busy(busy_s), .frame_done(done_s), .frame_err(err_s), .dbg_state(state_s)
  );

  pixel_tx_framer #(.DEPTH(16), .PAYLOAD_LEN(4096), .HEADER(8'hA5)) dut_l (
    .CLK(CLK), .RST_N(RST_N), .frame_start(fs_l), .io(l_if),
    .busy(busy_l), .frame_done(done_l), .frame_err(err_l), .dbg_state(state_l)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural uart_tx models and monitors
  int s_len = 10, l_len = 320;
  int s_cnt = 0, l_cnt = 0;
  logic [7:0] rx_s[$];
  logic [7:0] rx_l[$];
  int s_done_cnt = 0, s_done_bad = 0, s_viol = 0;
  int l_pulses = 0, l_viol = 0;
  logic s_prev_start = 1'b0, l_prev_start = 1'b0;

  assign s_if.tx_active = (s_cnt != 0);
  assign l_if.tx_active = (l_cnt != 0);

  always @(posedge CLK) begin
    if (s_cnt > 0) s_cnt <= s_cnt - 1;
    s_prev_start <= s_if.tx_start;
    if (s_if.tx_start) begin
      rx_s.push_back(s_if.tx_data);
      s_cnt <= s_len;
      if (s_if.tx_active || s_prev_start) s_viol <= s_viol + 1;
    end
    if (done_s) s_done_cnt <= s_done_cnt + 1;
    if (done_s && !s_if.tx_start) s_done_bad <= s_done_bad + 1;
  end

  always @(posedge CLK) begin
    if (l_cnt > 0) l_cnt <= l_cnt - 1;
    l_prev_start <= l_if.tx_start;
    if (l_if.tx_start) begin
      rx_l.push_back(l_if.tx_data);
      l_cnt <= l_len;
      l_pulses <= l_pulses + 1;
      if (l_if.tx_active || l_prev_start) l_viol <= l_viol + 1;
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k * 7 + 3);
  endfunction

  // driver tasks (all called at a negedge)
  task automatic push_byte(input bit big, input logic [7:0] b, input string tag);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 4000) begin
      if (big) begin l_if.in_data = b; l_if.in_valid = 1'b1; end
      else     begin s_if.in_data = b; s_if.in_valid = 1'b1; end
      #1;
      ok = big ? l_if.in_ready : s_if.in_ready;
      @(negedge CLK);
      n++;
    end
    if (big) l_if.in_valid = 1'b0;
    else     s_if.in_valid = 1'b0;
    if (!ok) check({tag, "_push_in_time"}, 32'(ok), 1);
  endtask

  task automatic pulse_start(input bit big);
    if (big) fs_l = 1'b1; else fs_s = 1'b1;
    @(negedge CLK);
    fs_l = 1'b0;
    fs_s = 1'b0;
  endtask

  task automatic wait_idle(input bit big, input int budget, input string tag);
    int n = 0;
    while ((big ? busy_l : busy_s) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_idle_in_time"}, 32'(big ? busy_l : busy_s), 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic compare_frame_s(input string tag);
    check({tag, "_len"}, rx_s.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [7:0] e;
      logic [7:0] g;
      e = exp_q.pop_front();
      g = (rx_s.size() > 0) ? rx_s.pop_front() : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(e));
    end
    rx_s.delete();
  endtask

  task automatic send_frame_s(input logic [7:0] p0, p1, p2, p3, input string tag);
    push_byte(1'b0, p0, tag);
    push_byte(1'b0, p1, tag);
    push_byte(1'b0, p2, tag);
    push_byte(1'b0, p3, tag);
    pulse_start(1'b0);
  endtask

  // main sequence
  initial begin
    int base_done, n, accepted, first_low, bad;
    bit ok;
    logic [7:0] xs;

    // Reset held for 3 cycles with inputs active.
    s_if.in_valid = 1'b1; s_if.in_data = 8'h77;
    l_if.in_valid = 1'b1; l_if.in_data = 8'h77;
    fs_s = 1'b1; fs_l = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 32'(busy_s), 0);
    check("rst_tx_start", 32'(s_if.tx_start), 0);
    check("rst_tx_data", 32'(s_if.tx_data), 0);
    check("rst_in_ready", 32'(s_if.in_ready), 1);
    check("rst_frame_err", 32'(err_s), 0);
    check("rst_state", 32'(state_s), 32'(ST_IDLE));
    check("rst_busy_l", 32'(busy_l), 0);
    RST_N = 1'b1;
    s_if.in_valid = 1'b0; l_if.in_valid = 1'b0;
    fs_s = 1'b0; fs_l = 1'b0;
    @(negedge CLK);

    // No byte may have entered during reset: an empty frame stalls after the header.
    pulse_start(1'b0);
    check("hdr_latency_start", 32'(s_if.tx_start), 1);
    check("hdr_latency_data", 32'(s_if.tx_data), 32'h A5);
    repeat (40) @(negedge CLK);
    check("rst_no_push_rx", rx_s.size(), 1);
    check("rst_no_push_state", 32'(state_s), 32'(ST_PAY));
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("abort_busy", 32'(busy_s), 0);
    repeat (12) @(negedge CLK);
    rx_s.delete();

    // Basic frame.
    base_done = s_done_cnt;
    send_frame_s(8'h01, 8'h02, 8'h03, 8'h04, "basic");
    wait_idle(1'b0, 300, "basic");
    exp_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    compare_frame_s("basic");
    check("basic_done_count", s_done_cnt - base_done, 1);
    check("basic_done_with_start", s_done_bad, 0);
    check("basic_busy_after", 32'(busy_s), 0);

    // frame_start during PAY is flagged and otherwise ignored.
    push_byte(1'b0, 8'h10, "err"); push_byte(1'b0, 8'h20, "err");
    push_byte(1'b0, 8'h30, "err"); push_byte(1'b0, 8'h40, "err");
    pulse_start(1'b0);
    n = 0;
    while (!(state_s == ST_PAY && rx_s.size() >= 2) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("err_reached_pay", 32'(state_s), 32'(ST_PAY));
    pulse_start(1'b0);
    check("err_flag_set", 32'(err_s), 1);
    wait_idle(1'b0, 300, "err");
    repeat (20) @(negedge CLK);
    exp_q = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40};
    compare_frame_s("err");
    send_frame_s(8'h05, 8'h06, 8'h07, 8'h08, "err2");
    wait_idle(1'b0, 300, "err2");
    exp_q = '{8'hA5, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0C};
    compare_frame_s("err2");
    check("err_flag_sticky", 32'(err_s), 1);

    // Reset after two payload bytes, then a fresh frame.
    send_frame_s(8'h11, 8'h22, 8'h33, 8'h44, "midrst");
    n = 0;
    while (rx_s.size() < 3 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("midrst_two_sent", rx_s.size(), 3);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("midrst_state", 32'(state_s), 32'(ST_IDLE));
    check("midrst_in_ready", 32'(s_if.in_ready), 1);
    check("midrst_err_clear", 32'(err_s), 0);
    rx_s.delete();
    repeat (15) @(negedge CLK);
    check("midrst_no_resend", rx_s.size(), 0);
    send_frame_s(8'h0A, 8'h0B, 8'h0C, 8'h0D, "fresh");
    wait_idle(1'b0, 300, "fresh");
    exp_q = '{8'hA5, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00};
    compare_frame_s("fresh");
    check("small_spacing_violations", s_viol, 0);

    // Large frame: backpressure with a slow UART, then the rest with a fast one.
    pulse_start(1'b1);
    accepted = 0;
    first_low = -1;
    n = 0;
    while (accepted < 24 && n < 20000) begin
      l_if.in_data = pat(accepted);
      l_if.in_valid = 1'b1;
      #1;
      ok = l_if.in_ready;
      if (!ok && first_low < 0) first_low = accepted;
      @(negedge CLK);
      if (ok) accepted++;
      n++;
    end
    l_if.in_valid = 1'b0;
    check("bp_full_at", 32'(first_low), 16);
    check("bp_accepted", accepted, 24);
    n = 0;
    while (rx_l.size() < 25 && n < 12000) begin
      @(negedge CLK);
      n++;
    end
    check("bp_rx_count", 32'(rx_l.size() >= 25), 1);
    check("bp_header", 32'(rx_l[0]), 32'hA5);
    for (int i = 0; i < 24; i++) check($sformatf("bp_byte%0d", i), 32'(rx_l[i+1]), 32'(pat(i)));

    l_len = 3;
    for (int k = 24; k < 4096; k++) push_byte(1'b1, pat(k), "big");
    wait_idle(1'b1, 3000, "big");
    bad = 0;
    xs = 8'h00;
    for (int k = 0; k < 4096; k++) begin
      xs ^= pat(k);
      if (k + 1 >= rx_l.size() || rx_l[k+1] !== pat(k)) bad++;
    end
    check("big_rx_count", rx_l.size(), 4098);
    check("big_pulses", l_pulses, 4098);
    check("big_spacing_violations", l_viol, 0);
    check("big_payload_mismatches", bad, 0);
    check("big_checksum", 32'(rx_l[rx_l.size()-1]), 32'(xs));
    check("big_err_clear", 32'(err_l), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
